// File: rtl/telegraph_pkg.sv
// Telegraph link receiver shared types.
// State encoding, default sync word, payload length helper.
package telegraph_pkg;

  typedef enum logic [1:0] {
    HUNT,
    ADDR,
    LEN,
    DATA
  } state_t;

  localparam logic [3:0] SYNC_DEFAULT = 4'b1011;

  // Length field encodes payload bits minus one.
  function automatic int unsigned payloadLen(
    input int unsigned field
  );
    return field + 1;
  endfunction

endpackage

// File: rtl/telegraph_frame_rx_if.sv
// Serial side and channel side signals of the frame receiver.
// master drives the stream, slave is the receiver.
interface telegraph_frame_rx_if #(
  parameter int N_CH  = 4,
  parameter int LEN_W = 4
);
  localparam int ADDR_W = $clog2(N_CH);

  logic              SerIn;
  logic              ClkEn;
  logic              SerOut;
  logic [N_CH-1:0]   SerOutValid;
  logic              Busy;
  logic [ADDR_W-1:0] Chan;
  logic [LEN_W:0]    CntOut;
  logic              Done;
  logic              Err;

  modport master (
    output SerIn, ClkEn,
    input  SerOut, SerOutValid, Busy,
    input  Chan, CntOut, Done, Err
  );

  modport slave (
    input  SerIn, ClkEn,
    output SerOut, SerOutValid, Busy,
    output Chan, CntOut, Done, Err
  );

endinterface

// File: rtl/telegraph_sync_detect.sv
// Sliding sync word window with compare.
// Match fires on the accepted bit that completes the pattern.
module telegraph_sync_detect
  import telegraph_pkg::*;
#(
  parameter int                SYNC_W    = 4,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_DEFAULT
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Shift,
  input  logic Clear,
  input  logic SerBit,
  output logic Match
);

  logic [SYNC_W-1:0] window;
  logic [SYNC_W-1:0] nextWin;

  assign nextWin = {window[SYNC_W-2:0], SerBit};
  assign Match   = Shift && (nextWin == SYNC_WORD);

  // Window slides on every hunted bit, cleared at frame end.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      window <= '0;
    end else if (Clear) begin
      window <= '0;
    end else if (Shift) begin
      window <= nextWin;
    end
  end

endmodule

// File: rtl/telegraph_frame_rx.sv
// Telegraph frame receiver: sync hunt, addr/len fields, payload.
// Payload bits are steered to one of N_CH channel strobes.
module telegraph_frame_rx
  import telegraph_pkg::*;
#(
  parameter int                SYNC_W    = 4,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_DEFAULT,
  parameter int                N_CH      = 4,
  parameter int                LEN_W     = 4
) (
  input logic Clk,
  input logic Rst,
  telegraph_frame_rx_if.slave Bus
);

  localparam int ADDR_W = $clog2(N_CH);
  localparam int CNT_W  = LEN_W + 1;
  localparam int FLD_W  = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
  localparam int FC_W   = $clog2(FLD_W + 1);
  localparam int unsigned NCH_U = N_CH;

  state_t            state;
  state_t            stateNext;
  logic [FC_W-1:0]   fieldCnt;
  logic [ADDR_W-1:0] chanQ;
  logic [LEN_W-1:0]  lenQ;
  logic [CNT_W-1:0]  cntQ;
  logic [CNT_W-1:0]  cntInc;
  logic [N_CH-1:0]   validQ;
  logic              serOutQ;
  logic              busyQ;
  logic              doneQ;
  logic              errQ;

  logic huntShift;
  logic syncHit;
  logic addrTake;
  logic addrLast;
  logic lenTake;
  logic lenLast;
  logic dataTake;
  logic dataLast;
  logic winClear;
  logic chanOk;

  telegraph_sync_detect #(
    .SYNC_W    (SYNC_W),
    .SYNC_WORD (SYNC_WORD)
  ) uSync (
    .Clk    (Clk),
    .Rst    (Rst),
    .Shift  (huntShift),
    .Clear  (winClear),
    .SerBit (Bus.SerIn),
    .Match  (syncHit)
  );

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= HUNT;
    end else begin
      state <= stateNext;
    end
  end

  // Next state: only accepted bits move the frame along.
  always_comb begin
    stateNext = state;
    unique case (1'b1)
      syncHit:  stateNext = ADDR;
      addrLast: stateNext = LEN;
      lenLast:  stateNext = DATA;
      dataLast: stateNext = HUNT;
      default:  ;
    endcase
  end

  // Per-state strobes for the datapath, qualified by ClkEn.
  always_comb begin
    huntShift = 1'b0;
    addrTake  = 1'b0;
    lenTake   = 1'b0;
    dataTake  = 1'b0;
    if (Bus.ClkEn) begin
      unique case (1'b1)
        state == HUNT: huntShift = 1'b1;
        state == ADDR: addrTake  = 1'b1;
        state == LEN:  lenTake   = 1'b1;
        state == DATA: dataTake  = 1'b1;
        default:       ;
      endcase
    end
    cntInc   = cntQ + CNT_W'(1);
    chanOk   = 32'(chanQ) < NCH_U;
    addrLast = addrTake &&
      (fieldCnt == FC_W'(ADDR_W - 1));
    lenLast  = lenTake &&
      (fieldCnt == FC_W'(LEN_W - 1));
    dataLast = dataTake &&
      (cntInc == CNT_W'(payloadLen(32'(lenQ))));
    winClear = dataLast;
  end

  // Field shifters, bit counter and output pulse registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      fieldCnt <= '0;
      chanQ    <= '0;
      lenQ     <= '0;
      cntQ     <= '0;
      validQ   <= '0;
      serOutQ  <= 1'b0;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
      errQ     <= 1'b0;
    end else begin
      validQ <= '0;
      doneQ  <= 1'b0;
      errQ   <= 1'b0;
      if (syncHit) begin
        busyQ    <= 1'b1;
        cntQ     <= '0;
        fieldCnt <= '0;
      end
      if (addrTake) begin
        chanQ    <= ADDR_W'({chanQ, Bus.SerIn});
        fieldCnt <= addrLast ? '0 : fieldCnt + FC_W'(1);
      end
      if (lenTake) begin
        lenQ     <= LEN_W'({lenQ, Bus.SerIn});
        fieldCnt <= lenLast ? '0 : fieldCnt + FC_W'(1);
      end
      if (dataTake) begin
        serOutQ <= Bus.SerIn;
        cntQ    <= cntInc;
        validQ  <= chanOk ? (N_CH'(1) << chanQ) : '0;
        if (dataLast) begin
          doneQ <= chanOk;
          errQ  <= !chanOk;
          busyQ <= 1'b0;
        end
      end
    end
  end

  assign Bus.SerOut      = serOutQ;
  assign Bus.SerOutValid = validQ;
  assign Bus.Busy        = busyQ;
  assign Bus.Chan        = chanQ;
  assign Bus.CntOut      = cntQ;
  assign Bus.Done        = doneQ;
  assign Bus.Err         = errQ;

endmodule

// File: tb/tb_telegraph_frame_rx.sv
// Bench for telegraph_frame_rx with N_CH=4 and N_CH=3 instances.
// Frame-level reference model plus literal scenario expectations.
module tb_telegraph_frame_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic serIn = 1'b0;
  logic clkEn = 1'b0;

  always #5 clk = ~clk;

  telegraph_frame_rx_if #(.N_CH(4), .LEN_W(4)) b4 ();
  telegraph_frame_rx_if #(.N_CH(3), .LEN_W(4)) b3 ();

  assign b4.SerIn = serIn;
  assign b4.ClkEn = clkEn;
  assign b3.SerIn = serIn;
  assign b3.ClkEn = clkEn;

  telegraph_frame_rx #(
    .SYNC_W(4), .SYNC_WORD(4'b1011), .N_CH(4), .LEN_W(4)
  ) dut4 (
    .Clk(clk), .Rst(rst), .Bus(b4)
  );

  telegraph_frame_rx #(
    .SYNC_W(4), .SYNC_WORD(4'b1011), .N_CH(3), .LEN_W(4)
  ) dut3 (
    .Clk(clk), .Rst(rst), .Bus(b3)
  );

  int checks = 0;
  int failures = 0;

  function automatic void check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endfunction

  // Reference model: position in frame, -1 while hunting.
  int mPos[2], mWin[2], mChan[2], mLen[2], mCnt[2];
  int mSer[2], mValid[2], mBusy[2], mDone[2], mErr[2];

  initial forever begin
    @(posedge clk or posedge rst);
    for (int d = 0; d < 2; d++) begin
      int nch;
      nch = (d == 0) ? 4 : 3;
      if (rst) begin
        mPos[d] = -1; mWin[d] = 0; mChan[d] = 0;
        mLen[d] = 0; mCnt[d] = 0; mSer[d] = 0;
        mValid[d] = 0; mBusy[d] = 0;
        mDone[d] = 0; mErr[d] = 0;
      end else begin
        mValid[d] = 0; mDone[d] = 0; mErr[d] = 0;
        if (clkEn) begin
          if (mPos[d] < 0) begin
            mWin[d] = ((mWin[d] << 1) | int'(serIn)) & 15;
            if (mWin[d] == 11) begin
              mPos[d] = 0; mBusy[d] = 1; mCnt[d] = 0;
            end
          end else if (mPos[d] < 2) begin
            mChan[d] = ((mChan[d] << 1) | int'(serIn)) & 3;
            mPos[d]++;
          end else if (mPos[d] < 6) begin
            mLen[d] = ((mLen[d] << 1) | int'(serIn)) & 15;
            mPos[d]++;
          end else begin
            mSer[d] = int'(serIn);
            mCnt[d]++;
            if (mChan[d] < nch) mValid[d] = 1 << mChan[d];
            if (mCnt[d] == mLen[d] + 1) begin
              if (mChan[d] < nch) mDone[d] = 1;
              else mErr[d] = 1;
              mBusy[d] = 0; mPos[d] = -1; mWin[d] = 0;
            end
          end
        end
      end
    end
  end

  // Monitor counters, owned by the compare process.
  int vCnt4[4];
  int vTot3 = 0, pulses4 = 0;
  int done4 = 0, err4 = 0, done3 = 0, err3 = 0;
  int bits4 = 0;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("SerOut4", b4.SerOut, mSer[0]);
      check("Valid4", int'(b4.SerOutValid), mValid[0]);
      check("Busy4", b4.Busy, mBusy[0]);
      check("Chan4", int'(b4.Chan), mChan[0]);
      check("Cnt4", int'(b4.CntOut), mCnt[0]);
      check("Done4", b4.Done, mDone[0]);
      check("Err4", b4.Err, mErr[0]);
      check("SerOut3", b3.SerOut, mSer[1]);
      check("Valid3", int'(b3.SerOutValid), mValid[1]);
      check("Busy3", b3.Busy, mBusy[1]);
      check("Chan3", int'(b3.Chan), mChan[1]);
      check("Cnt3", int'(b3.CntOut), mCnt[1]);
      check("Done3", b3.Done, mDone[1]);
      check("Err3", b3.Err, mErr[1]);
      for (int c = 0; c < 4; c++)
        if (b4.SerOutValid[c]) vCnt4[c]++;
      if (b4.SerOutValid != 4'b0) begin
        pulses4++;
        bits4 = (bits4 << 1) | int'(b4.SerOut);
      end
      if (b3.SerOutValid != 3'b0) vTot3++;
      if (b4.Done) done4++;
      if (b4.Err) err4++;
      if (b3.Done) done3++;
      if (b3.Err) err3++;
    end
  end

  int sV[4];
  int sTot3, sPulses, sDone4, sErr4, sDone3, sErr3;

  task automatic snap();
    for (int c = 0; c < 4; c++) sV[c] = vCnt4[c];
    sTot3 = vTot3; sPulses = pulses4;
    sDone4 = done4; sErr4 = err4;
    sDone3 = done3; sErr3 = err3;
  endtask

  task automatic sendBit(input logic b, input int gap);
    serIn = b;
    clkEn = 1'b1;
    @(negedge clk);
    clkEn = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic sendBits(
    input logic [31:0] v, input int n, input int gap
  );
    for (int i = n - 1; i >= 0; i--) sendBit(v[i], gap);
  endtask

  task automatic sendFrame(
    input int a, input int len,
    input logic [15:0] pay, input int gap
  );
    sendBits(32'hB, 4, gap);
    sendBits(32'(a), 2, gap);
    sendBits(32'(len), 4, gap);
    sendBits(32'(pay), len + 1, gap);
  endtask

  task automatic idle(input int n);
    serIn = 1'b0;
    clkEn = 1'b1;
    repeat (n) @(negedge clk);
    clkEn = 1'b0;
  endtask

  task automatic allZero(input string tag);
    check({tag, "_ser4"}, b4.SerOut, 0);
    check({tag, "_val4"}, int'(b4.SerOutValid), 0);
    check({tag, "_busy4"}, b4.Busy, 0);
    check({tag, "_chan4"}, int'(b4.Chan), 0);
    check({tag, "_cnt4"}, int'(b4.CntOut), 0);
    check({tag, "_done4"}, b4.Done, 0);
    check({tag, "_err4"}, b4.Err, 0);
    check({tag, "_val3"}, int'(b3.SerOutValid), 0);
    check({tag, "_busy3"}, b3.Busy, 0);
    check({tag, "_cnt3"}, int'(b3.CntOut), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    for (int c = 0; c < 4; c++) vCnt4[c] = 0;
    repeat (2) @(negedge clk);
    #1;
    allZero("reset");
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    // Nominal frame: addr 2, len 3, payload 1001.
    snap();
    sendFrame(2, 3, 16'b1001, 0);
    idle(3);
    #1;
    check("s1_val2", vCnt4[2] - sV[2], 4);
    check("s1_pulses", pulses4 - sPulses, 4);
    check("s1_bits", bits4 & 15, 9);
    check("s1_done4", done4 - sDone4, 1);
    check("s1_err4", err4 - sErr4, 0);
    check("s1_done3", done3 - sDone3, 1);
    check("s1_cnt", int'(b4.CntOut), 4);
    check("s1_chan", int'(b4.Chan), 2);
    check("s1_mcnt", mCnt[0], 4);

    // Overlapping sync: 1,1,0,1,1.
    snap();
    sendBits(32'b1101, 4, 0);
    #1;
    check("s2_early", b4.Busy, 0);
    sendBit(1'b1, 0);
    #1;
    check("s2_detect", b4.Busy, 1);
    sendBits(32'b00, 2, 0);
    sendBits(32'b0000, 4, 0);
    sendBit(1'b1, 0);
    idle(3);
    #1;
    check("s2_val0", vCnt4[0] - sV[0], 1);
    check("s2_pulses", pulses4 - sPulses, 1);
    check("s2_done4", done4 - sDone4, 1);

    // Address 3 is out of range for the 3-channel unit.
    snap();
    sendFrame(3, 1, 16'b10, 0);
    idle(3);
    #1;
    check("s3_val3", vTot3 - sTot3, 0);
    check("s3_err3", err3 - sErr3, 1);
    check("s3_done3", done3 - sDone3, 0);
    check("s3_busy3", b3.Busy, 0);
    check("s3_cnt3", int'(b3.CntOut), 2);
    check("s3_val4", vCnt4[3] - sV[3], 2);
    check("s3_done4", done4 - sDone4, 1);

    // Sparse strobe, one accepted bit every 5th cycle.
    snap();
    sendFrame(2, 3, 16'b1001, 4);
    idle(3);
    #1;
    check("s4_val2", vCnt4[2] - sV[2], 4);
    check("s4_pulses", pulses4 - sPulses, 4);
    check("s4_bits", bits4 & 15, 9);
    check("s4_done3", done3 - sDone3, 1);

    // Longest payload with an embedded sync pattern.
    snap();
    sendFrame(1, 15, 16'b1011_0110_1011_0001, 0);
    idle(3);
    #1;
    check("s5_val1", vCnt4[1] - sV[1], 16);
    check("s5_bits", bits4 & 16'hFFFF, 16'hB6B1);
    check("s5_done4", done4 - sDone4, 1);
    check("s5_cnt", int'(b4.CntOut), 16);
    check("s5_mcnt", mCnt[0], 16);

    // Asynchronous reset after the second payload bit.
    snap();
    sendBits(32'hB, 4, 0);
    sendBits(32'b01, 2, 0);
    sendBits(32'b0011, 4, 0);
    sendBit(1'b1, 0);
    sendBit(1'b0, 0);
    #2;
    rst = 1'b1;
    #1;
    allZero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    #1;
    check("s6_nodone", done4 - sDone4, 0);
    snap();
    sendFrame(1, 3, 16'b0110, 0);
    idle(3);
    #1;
    check("s6_val1", vCnt4[1] - sV[1], 4);
    check("s6_bits", bits4 & 15, 6);
    check("s6_done4", done4 - sDone4, 1);

    // Random frames with noise and strobe gaps.
    for (int f = 0; f < 40; f++) begin
      int nz;
      nz = $urandom_range(0, 3);
      for (int k = 0; k < nz; k++)
        sendBit(1'($urandom_range(0, 1)), $urandom_range(0, 1));
      sendFrame($urandom_range(0, 3), $urandom_range(0, 15),
                16'($urandom), $urandom_range(0, 2));
      idle($urandom_range(0, 2));
    end
    idle(24);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/telegraph_frame_rx.md
# telegraph_frame_rx

Parametrised serial frame receiver for the telegraph link. It hunts the sampled serial stream for a configurable sync word, with overlap-aware matching. It then reads an address field and a length field, and routes the variable-length payload bit-by-bit to one of N_CH output channels. The block sits between the bit-rate strobe generator (`ClkEn`) and the per-channel deserialisers.

## Interface
- `SYNC_W`, 4: sync word width in bits, ≥2.
- `SYNC_WORD`, 4'b1011: sync pattern, MSB received first.
- `N_CH`, 4: output channel count, ≥2; `ADDR_W = $clog2(N_CH)` is derived locally.
- `LEN_W`, 4: length field width; payload length is field value + 1 (1..2^LEN_W bits).

Ports:
- `Clk`  in  1  system clock, all logic on the rising edge.
- `Rst`  in  1  asynchronous, active-high reset.
- `SerIn`  in  1  serial data; sampled only when `ClkEn`=1.
- `ClkEn`  in  1  bit strobe; one accepted bit per Clk edge with `ClkEn`=1.
- `SerOut`  out  1  registered copy of the last accepted payload bit.
- `SerOutValid`  out  N_CH  one-hot; bit `ch` pulses for one Clk per payload bit delivered to channel `ch`.
- `Busy`  out  1  high from sync detect until the frame ends.
- `Chan`  out  ADDR_W  address of the current or last frame.
- `CntOut`  out  LEN_W+1  payload bits delivered in the current frame.
- `Done`  out  1  one-Clk pulse after the last payload bit of a valid-address frame.
- `Err`  out  1  one-Clk pulse after the last payload bit of a frame with address ≥ N_CH.

## Operation
- States are HUNT, ADDR, LEN and DATA. A transition happens only on an edge with `ClkEn`=1.
- HUNT
  - An SYNC_W-bit window shifts in `SerIn` on every accepted bit.
  - When the window plus the incoming bit equals SYNC_WORD, go to ADDR, clear `CntOut` and set `Busy`.
  - Matching slides, so overlapping candidates are not lost. Example: 1,1,0,1,1 detects 1011 on the fifth bit.
- ADDR
  - Shift ADDR_W bits into `Chan`, MSB first, then go to LEN.
- LEN
  - Shift LEN_W bits into the length register, MSB first, then go to DATA.
- DATA
  - On each accepted bit, `SerOut`←`SerIn` and `CntOut`←`CntOut`+1.
  - If `Chan` < N_CH, pulse `SerOutValid[Chan]`. Otherwise all valid bits stay 0 and the payload is silently consumed.
  - On the bit where `CntOut` reaches length+1:
    - pulse `Done` (valid address) or `Err` (invalid address);
    - drop `Busy`;
    - go to HUNT with the window cleared to all zeros.
- A sync pattern inside ADDR, LEN or DATA is treated as data. There is no resynchronisation mid-frame.
- `Chan` and `CntOut` hold their values after the frame until the next sync detect.

## Timing
- Reset, asynchronous: state is HUNT and the window is 0. `SerOut`, `SerOutValid`, `Busy`, `Chan`, `CntOut`, `Done` and `Err` are all 0.
- Reset mid-frame aborts the frame immediately. No `Done` or `Err` is produced.
- Latency: a payload bit sampled at edge k appears on `SerOut`/`SerOutValid` after edge k. `Done`/`Err` rise together with the last bit's valid.
- `SerOutValid`, `Done` and `Err` are single-Clk pulses. They clear on the next Clk edge whether `ClkEn` is high or low.
- `SerOut` holds its value between pulses.
- With `ClkEn`=0, nothing advances except the pulse clearing.
- With `ClkEn`=1 every cycle, back-to-back frames are legal. The first sync bit may immediately follow the last payload bit.
- Frame length in accepted bits: SYNC_W + ADDR_W + LEN_W + length + 1.

## Structure
- `telegraph_pkg` holds:
  - the state enum (HUNT, ADDR, LEN, DATA);
  - the default sync word constant;
  - a function for the payload length (field + 1).
- One sub-module, `telegraph_sync_detect`:
  - parametrised window shift register with compare;
  - `clear` input;
  - outputs a `match` strobe.
- The top level holds the FSM, field shift registers, bit counter and output registers.

## Test plan
- Defaults. Send 1011, addr 10, len 0011, payload 1,0,0,1 with continuous `ClkEn`.
  - Expect `SerOutValid`=4'b0100 pulsed 4 times with `SerOut`=1,0,0,1.
  - Expect `Done` on the 4th pulse, `CntOut`=4, `Chan`=2.
- Overlap. Pre-frame bits 1,1,0,1,1, where the last four form the sync, then addr 00, len 0000, payload 1.
  - Expect detection after the 5th bit and a single `SerOutValid[0]` pulse.
- Invalid address with N_CH=3. Send addr 11, len 0001.
  - Expect no `SerOutValid` pulses, `Err` pulse after 2 payload bits, no `Done`, then a return to HUNT.
- Sparse strobe. Use `ClkEn` every 5th cycle with the first scenario's frame.
  - Expect identical data, with each pulse exactly one Clk wide.
- Maximum length. Send len 1111 and 16 payload bits containing 1011.
  - Expect 16 valid pulses, no resync and `CntOut`=16.
- Reset. Assert `Rst` asynchronously after the 2nd payload bit.
  - Expect all outputs 0 at once and no `Done`.
  - A following full frame is received correctly.
